// File: rtl/player_pkg.sv
// ============================================================================
//  Module      : player_pkg
//  Description : Shared types and constants for the player motion controller:
//                FSM state type, direction indices, status codes, playfield
//                geometry and a saturating position-step helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    MOVE = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Direction indices match the bit positions of the button bus.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [2:0] STATUS_IDLE    = 3'b001;
  localparam logic [2:0] STATUS_MOVE    = 3'b010;
  localparam logic [2:0] STATUS_BLOCKED = 3'b100;

  localparam int unsigned PLAYER_SIZE = 12;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;

  // Adds a signed step to an unsigned position in 33-bit signed arithmetic
  // so a step below zero cannot wrap, then clamps to [lo, hi].
  function automatic logic [31:0] sat_add(input logic [31:0]        pos,
                                          input logic signed [32:0] delta,
                                          input logic [31:0]        lo,
                                          input logic [31:0]        hi);
    logic signed [32:0] sum;
    sum = $signed({1'b0, pos}) + delta;
    if (sum < $signed({1'b0, lo}))
      return lo;
    else if (sum > $signed({1'b0, hi}))
      return hi;
    else
      return sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Two-flop synchroniser per button followed by a registered
//                rising-edge pulse. A press on the pin shows up as a one-cycle
//                pulse on rise three clock edges later.
//  Ports       : clk   - clock
//                rst   - asynchronous active-high reset
//                raw   - asynchronous button inputs
//                level - synchronised button levels
//                rise  - one-cycle rising-edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_sync_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_rise <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign level = r_sync;
  assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/player_move_ctrl.sv
// ============================================================================
//  Module      : player_move_ctrl
//  Description : Player-object motion sequencer. Synchronises and edge-detects
//                the direction buttons, arbitrates simultaneous presses
//                (up > down > left > right), commits one STEP move per accepted
//                press on a frame tick, honours per-direction enables and
//                clamps the position to the playfield.
//  Ports       : btnClk      - system clock
//                rst         - asynchronous active-high reset
//                btns[3:0]   - raw buttons [0]up [1]down [2]left [3]right
//                *Enable     - per-direction move permits
//                tick        - frame strobe, moves commit only on tick
//                hPos/vPos   - current position
//                hOffset/vOffset - position minus start position
//                moving      - one-cycle pulse when a move commits
//                status      - one-hot 001 idle / 010 pending / 100 blocked
//  Options     : AUTO_REPEAT_EN - when defined, a held button repeats its
//                move every REPEAT_TICKS ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_move_ctrl
  import player_pkg::*;
#(
  parameter int unsigned STEP    = PLAYER_SIZE,
  parameter int unsigned H_START = SCREEN_W / 2 - PLAYER_SIZE,
  parameter int unsigned V_START = SCREEN_H - 8 * PLAYER_SIZE,
  parameter int unsigned H_MIN   = 0,
  parameter int unsigned H_MAX   = SCREEN_W - PLAYER_SIZE,
  parameter int unsigned V_MIN   = 0,
  parameter int unsigned V_MAX   = SCREEN_H - PLAYER_SIZE
`ifdef AUTO_REPEAT_EN
  , parameter int unsigned REPEAT_TICKS = 8
`endif
) (
  input  logic        btnClk,
  input  logic        rst,
  input  logic [3:0]  btns,
  input  logic        upEnable,
  input  logic        downEnable,
  input  logic        leftEnable,
  input  logic        rightEnable,
  input  logic        tick,
  output logic [31:0] hPos,
  output logic [31:0] vPos,
  output logic [31:0] hOffset,
  output logic [31:0] vOffset,
  output logic        moving,
  output logic [2:0]  status
);

  logic [3:0] w_level;
  logic [3:0] w_rise;

  btn_sync_edge #(.WIDTH(4)) u_sync (
    .clk   (btnClk),
    .rst   (rst),
    .raw   (btns),
    .level (w_level),
    .rise  (w_rise)
  );

  state_t      r_state;
  logic [1:0]  r_dir;
  logic [31:0] r_hpos;
  logic [31:0] r_vpos;
  logic [31:0] r_hoff;
  logic [31:0] r_voff;
  logic        r_moving;
  logic [2:0]  r_status;
  logic        r_blocked;

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_TICKS) + 1;
  logic [CW-1:0] r_rep_cnt;
`endif

  logic               w_any;
  logic [1:0]         w_sel;
  logic [3:0]         w_en;
  logic signed [32:0] w_step;
  logic [31:0]        w_h_next;
  logic [31:0]        w_v_next;

  assign w_en   = {rightEnable, leftEnable, downEnable, upEnable};
  assign w_step = $signed(33'(STEP));
  assign w_any  = |w_rise;

  // Fixed priority: lowest button index wins, simultaneous losers are dropped.
  always_comb begin
    w_sel = DIR_UP;
    if (w_rise[0])      w_sel = DIR_UP;
    else if (w_rise[1]) w_sel = DIR_DOWN;
    else if (w_rise[2]) w_sel = DIR_LEFT;
    else if (w_rise[3]) w_sel = DIR_RIGHT;
  end

  always_comb begin
    w_h_next = r_hpos;
    w_v_next = r_vpos;
    case (r_dir)
      DIR_UP:    w_v_next = sat_add(r_vpos, -w_step, 32'(V_MIN), 32'(V_MAX));
      DIR_DOWN:  w_v_next = sat_add(r_vpos,  w_step, 32'(V_MIN), 32'(V_MAX));
      DIR_LEFT:  w_h_next = sat_add(r_hpos, -w_step, 32'(H_MIN), 32'(H_MAX));
      DIR_RIGHT: w_h_next = sat_add(r_hpos,  w_step, 32'(H_MIN), 32'(H_MAX));
      default: ;
    endcase
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dir     <= DIR_UP;
      r_hpos    <= 32'(H_START);
      r_vpos    <= 32'(V_START);
      r_hoff    <= '0;
      r_voff    <= '0;
      r_moving  <= 1'b0;
      r_status  <= STATUS_IDLE;
      r_blocked <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_moving <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_dir    <= w_sel;
            r_status <= STATUS_MOVE;
            r_state  <= PEND;
          end
        end
        // Enables are sampled only at the committing tick.
        PEND: begin
          if (tick) begin
            if (w_en[r_dir]) begin
              r_state <= MOVE;
            end else begin
              r_status  <= STATUS_BLOCKED;
              r_blocked <= 1'b1;
              r_state   <= HOLD;
            end
          end
        end
        // A saturated move with no net change still counts as a move.
        MOVE: begin
          r_hpos    <= w_h_next;
          r_vpos    <= w_v_next;
          r_hoff    <= w_h_next - 32'(H_START);
          r_voff    <= w_v_next - 32'(V_START);
          r_moving  <= 1'b1;
          r_status  <= STATUS_MOVE;
          r_blocked <= 1'b0;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (w_level == 4'b0000) begin
            r_status <= r_blocked ? STATUS_BLOCKED : STATUS_IDLE;
            r_state  <= IDLE;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt <= '0;
          end else if (!w_level[r_dir]) begin
            r_rep_cnt <= '0;
          end else if (tick) begin
            if (r_rep_cnt == CW'(REPEAT_TICKS - 1)) begin
              r_rep_cnt <= '0;
              if (w_en[r_dir]) begin
                r_state <= MOVE;
              end else begin
                r_status  <= STATUS_BLOCKED;
                r_blocked <= 1'b1;
              end
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hPos    = r_hpos;
  assign vPos    = r_vpos;
  assign hOffset = r_hoff;
  assign vOffset = r_voff;
  assign moving  = r_moving;
  assign status  = r_status;

endmodule

`default_nettype wire
